boreal_channel_scheduler: RTL and testbench

Frame-level channel sequencer for the 8-channel adaptive inference core. It accepts one 8-channel ADC frame at a time and steps the core through each enabled channel in ascending order. For each channel it drives `ch` and a one-cycle `adc_valid` strobe, then waits for the core's per-channel completion. It also counts dropped frames and, optionally, recovers from a hung channel slot with a watchdog.

---
 rtl/boreal_channel_scheduler_pkg.sv | 21 ++
 rtl/boreal_channel_scheduler_if.sv | 40 ++++
 rtl/boreal_channel_scheduler_rr_picker.sv | 31 +++
 rtl/boreal_channel_scheduler.sv | 147 ++++++++++++++
 tb/tb_boreal_channel_scheduler.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/boreal_channel_scheduler_pkg.sv
// +----------------------------------------------------------------------+
// | boreal_sched_pkg: shared types and constants for the channel sequencer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package boreal_sched_pkg;

  localparam int NUM_CH         = 8;
  localparam int CH_W           = 3;
  localparam int TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } sched_state_t;

endpackage

`default_nettype wire

// File: rtl/boreal_channel_scheduler_if.sv
// +----------------------------------------------------------------------+
// | boreal_channel_scheduler_if: frame / core handshake bundle           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface boreal_channel_scheduler_if
  import boreal_sched_pkg::*;
#(
  parameter int OVR_W = 16
) ();

  logic              frame_valid;
  logic [NUM_CH-1:0] ch_mask;
  logic              core_done;
  logic              clr_err;
  logic              frame_ready;
  logic [CH_W-1:0]   ch;
  logic              adc_valid;
  logic              frame_done;
  logic              busy;
  logic [OVR_W-1:0]  overrun_cnt;
  logic              timeout_err;
  logic [CH_W-1:0]   timeout_ch;

  modport slave (
    input  frame_valid, ch_mask, core_done, clr_err,
    output frame_ready, ch, adc_valid, frame_done, busy,
           overrun_cnt, timeout_err, timeout_ch
  );

  modport master (
    output frame_valid, ch_mask, core_done, clr_err,
    input  frame_ready, ch, adc_valid, frame_done, busy,
           overrun_cnt, timeout_err, timeout_ch
  );

endinterface

`default_nettype wire

// File: rtl/boreal_channel_scheduler_rr_picker.sv
// +----------------------------------------------------------------------+
// | boreal_rr_picker: lowest set mask bit, optionally above a channel    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module boreal_rr_picker
  import boreal_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur_ch,
  input  logic              first,
  output logic [CH_W-1:0]   next_ch,
  output logic              found
);

  // Scan downward so the lowest qualifying bit is the last one written.
  always_comb begin
    found   = 1'b0;
    next_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (CH_W'(i) > cur_ch))) begin
        found   = 1'b1;
        next_ch = CH_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/boreal_channel_scheduler.sv
// +----------------------------------------------------------------------+
// | boreal_channel_scheduler: steps the core through enabled channels.   |
// | Optional watchdog: define BOREAL_SCHED_WATCHDOG_EN.  Rev 1.0         |
// +----------------------------------------------------------------------+
`default_nettype none

module boreal_channel_scheduler #(
  parameter int NUM_CH         = boreal_sched_pkg::NUM_CH,
  parameter int TIMEOUT_CYCLES = boreal_sched_pkg::TIMEOUT_CYCLES,
  parameter int OVR_W          = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  boreal_channel_scheduler_if.slave  bus
);
  import boreal_sched_pkg::*;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  sched_state_t      state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              adc_valid_q, adc_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [OVR_W-1:0]  ovr_q, ovr_d;

  logic              pick_first;
  logic [NUM_CH-1:0] pick_mask;
  logic [CH_W-1:0]   pick_ch;
  logic              pick_found;
  logic              accept;
  logic              slot_end;
  logic              wd_fire;

  // The first pick of a frame looks at the live mask, later picks at the latched one.
  assign pick_first = (state_q == S_IDLE);
  assign pick_mask  = pick_first ? bus.ch_mask : mask_q;
  assign accept     = (state_q == S_IDLE) && bus.frame_valid;
  assign slot_end   = (state_q == S_WAIT) && !adc_valid_q && (bus.core_done || wd_fire);

  boreal_rr_picker u_picker (
    .mask    (pick_mask),
    .cur_ch  (ch_q),
    .first   (pick_first),
    .next_ch (pick_ch),
    .found   (pick_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      adc_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      mask_q       <= '0;
      ovr_q        <= '0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      adc_valid_q  <= adc_valid_d;
      frame_done_q <= frame_done_d;
      mask_q       <= mask_d;
      ovr_q        <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.frame_valid) state_d = pick_found ? S_WAIT : S_DONE;
      S_WAIT:  if (slot_end && !pick_found) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    adc_valid_d  = (accept || slot_end) && pick_found;
    ch_d         = adc_valid_d ? pick_ch : ch_q;
    frame_done_d = (state_d == S_DONE);
    mask_d       = accept ? bus.ch_mask : mask_q;
    ovr_d        = ovr_q;
    if (bus.frame_valid && (state_q != S_IDLE) && (ovr_q != {OVR_W{1'b1}})) begin
      ovr_d = ovr_q + OVR_W'(1);
    end
  end

`ifdef BOREAL_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            timeout_err_q, timeout_err_d;
  logic [CH_W-1:0] timeout_ch_q, timeout_ch_d;

  // Counter is zero in the strobe cycle, so it fires TIMEOUT_CYCLES cycles later.
  assign wd_fire = (state_q == S_WAIT) && !adc_valid_q && !bus.core_done &&
                   (wd_cnt_q == WD_W'(TIMEOUT_CYCLES));

  always_comb begin
    wd_cnt_d      = wd_cnt_q;
    timeout_err_d = timeout_err_q;
    timeout_ch_d  = timeout_ch_q;
    if (adc_valid_d) begin
      wd_cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
    if (wd_fire) begin
      timeout_err_d = 1'b1;
      timeout_ch_d  = ch_q;
    end else if (bus.clr_err) begin
      timeout_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
      timeout_ch_q  <= '0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
      timeout_ch_q  <= timeout_ch_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
  assign bus.timeout_ch  = timeout_ch_q;
`else
  assign wd_fire         = 1'b0;
  assign bus.timeout_err = 1'b0;
  assign bus.timeout_ch  = '0;
`endif

  assign bus.frame_ready = (state_q == S_IDLE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.ch          = ch_q;
  assign bus.adc_valid   = adc_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.overrun_cnt = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_boreal_channel_scheduler.sv
// +----------------------------------------------------------------------+
// | tb_boreal_channel_scheduler: randomized frames vs. a frame-level model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_boreal_channel_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  boreal_channel_scheduler_if #(.OVR_W(16)) bus   ();
  boreal_channel_scheduler_if #(.OVR_W(3))  bus_s ();

  boreal_channel_scheduler #(.OVR_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  boreal_channel_scheduler #(.OVR_W(3)) u_dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] m_ovr   = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    bus.frame_valid = 1'b0; bus.ch_mask = '0; bus.core_done = 1'b0; bus.clr_err = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_ch"}, bus.ch, 0);
    chk({tag, "_adc_valid"}, bus.adc_valid, 0);
    chk({tag, "_frame_done"}, bus.frame_done, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_frame_ready"}, bus.frame_ready, 1);
    chk({tag, "_overrun"}, bus.overrun_cnt, 0);
    chk({tag, "_timeout_err"}, bus.timeout_err, 0);
    chk({tag, "_timeout_ch"}, bus.timeout_ch, 0);
  endtask

  // One frame: expected strobes are the set mask bits, ascending; each strobe and
  // frame_done must land exactly one cycle after the event that causes it.
  task automatic run_frame(input logic [7:0] mask, input int fixed_dly, input int ovr_pct);
    int exp_q[$];
    int n, idx, k, g;
    int av_due, fd_due, done_at;
    for (int i = 0; i < 8; i++) if (mask[i]) exp_q.push_back(i);
    n = exp_q.size(); idx = 0; av_due = -1; fd_due = -1; done_at = -1;
    g = 0;
    while (!bus.frame_ready && g < 50) begin tick; g++; end
    bus.frame_valid = 1'b1; bus.ch_mask = mask;
    tick;
    if (n == 0) fd_due = 1; else av_due = 1;
    for (k = 1; k < 600; k++) begin
      chk("adc_valid", bus.adc_valid, k == av_due);
      chk("frame_done", bus.frame_done, k == fd_due);
      chk("busy", bus.busy, 1);
      if (bus.adc_valid && idx < n) begin
        chk("ch", bus.ch, exp_q[idx]);
        idx++;
        done_at = k + ((fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, 12)));
      end
      if (k == fd_due) break;
      bus.core_done = (k == done_at) || (bus.adc_valid && ($urandom_range(0, 3) == 0));
      if (k == done_at) begin
        if (idx == n) fd_due = k + 1; else av_due = k + 1;
      end
      bus.frame_valid = ($urandom_range(0, 99) < ovr_pct);
      if (bus.frame_valid && m_ovr != 16'hFFFF) m_ovr++;
      bus.ch_mask = 8'($urandom);
      bus.clr_err = 1'($urandom);
      tick;
    end
    if (k >= 600) chk("frame_timeout", 0, 1);
    idle_inputs;
    tick;
    chk("strobe_count", idx, n);
    chk("ready_after", bus.frame_ready, 1);
    chk("busy_after", bus.busy, 0);
    chk("frame_done_after", bus.frame_done, 0);
    chk("overrun_cnt", bus.overrun_cnt, m_ovr);
    chk("timeout_err", bus.timeout_err, 0);
  endtask

  task automatic sat_test;
    bus_s.frame_valid = 1'b1; bus_s.ch_mask = 8'h01; bus_s.core_done = 1'b0; bus_s.clr_err = 1'b0;
    tick;
    for (int i = 1; i <= 10; i++) begin
      bus_s.frame_valid = 1'b1;
      tick;
      chk("sat_overrun", bus_s.overrun_cnt, (i > 7) ? 7 : i);
    end
    bus_s.frame_valid = 1'b0; bus_s.core_done = 1'b1;
    tick;
    bus_s.core_done = 1'b0;
    chk("sat_frame_done", bus_s.frame_done, 1);
    tick;
  endtask

`ifdef BOREAL_SCHED_WATCHDOG_EN
  task automatic wd_test;
    int gap;
    bus.frame_valid = 1'b1; bus.ch_mask = 8'h18;
    tick;
    bus.frame_valid = 1'b0;
    chk("wd_first_av", bus.adc_valid, 1);
    chk("wd_first_ch", bus.ch, 3);
    gap = 0;
    do begin tick; gap++; end while (!bus.adc_valid && gap < 200);
    chk("wd_gap", gap, 65);
    chk("wd_next_ch", bus.ch, 4);
    chk("wd_err_set", bus.timeout_err, 1);
    chk("wd_timeout_ch", bus.timeout_ch, 3);
    bus.core_done = 1'b1;
    tick;
    bus.core_done = 1'b0;
    chk("wd_frame_done", bus.frame_done, 1);
    tick;
    chk("wd_err_sticky", bus.timeout_err, 1);
    bus.clr_err = 1'b1;
    tick;
    bus.clr_err = 1'b0;
    chk("wd_err_clr", bus.timeout_err, 0);
  endtask
`endif

  task automatic reset_test;
    int k, done_at;
    bus.frame_valid = 1'b1; bus.ch_mask = 8'hFF;
    tick;
    bus.frame_valid = 1'b0;
    done_at = -1;
    for (k = 1; k < 200; k++) begin
      if (bus.adc_valid) begin
        if (bus.ch == 3'd4) break;
        done_at = k + 2;
      end
      bus.core_done = (k == done_at);
      tick;
    end
    chk("rst_reached_ch4", bus.ch, 4);
    bus.core_done = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_values("async_rst");
    m_ovr = '0;
    tick;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("rst_no_frame_done", bus.frame_done, 0);
      chk("rst_ready", bus.frame_ready, 1);
    end
  endtask

  initial begin
    logic [7:0] mask;
    idle_inputs;
    bus_s.frame_valid = 1'b0; bus_s.ch_mask = '0; bus_s.core_done = 1'b0; bus_s.clr_err = 1'b0;
    rst = 1'b1;
    repeat (3) tick;
    chk_reset_values("reset");
    rst = 1'b0;
    tick;

    sat_test;
    run_frame(8'hFF, 9, 0);
    run_frame(8'hA4, 0, 0);
    run_frame(8'h00, 0, 0);
    run_frame(8'h81, 6, 50);
`ifdef BOREAL_SCHED_WATCHDOG_EN
    wd_test;
`endif
    for (int t = 0; t < 25; t++) begin
      mask = 8'($urandom);
      if (t % 8 == 3) mask = 8'h00;
      if (t % 8 == 6) mask = 8'hFF;
      run_frame(mask, 0, 15);
    end
    reset_test;
    run_frame(8'h0E, 0, 10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
